// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-lite response codes, responder FSM states and read/write grant type
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;
endpackage

// File: rtl/axi_lite_ram_slave_if.sv
// axi_lite_ram_slave_if: AXI-lite AW/W/B/AR/R channel bundle; master drives requests and readies for responses, slave the reverse
interface axi_lite_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI-lite responder (clk, rst, slave modport s) arbitrating one single-port RAM (ram_wr_en/be/addr/din out, ram_dout in)
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  axi_lite_ram_slave_if.slave s,
  output logic ram_wr_en,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  state_t state;
  grant_t last_grant;
  logic [CW-1:0] cnt;
  logic fresh;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic wr_cand, rd_cand, grant_wr, grant_rd, aw_oor, ar_oor;
  logic [MEM_ADDR_WIDTH-1:0] aw_word, ar_word;
  always_comb begin
    wr_cand = !rst && state == IDLE && s.awvalid && s.wvalid;
    rd_cand = !rst && state == IDLE && s.arvalid;
    grant_wr = wr_cand && (!rd_cand || last_grant == GRANT_READ);
    grant_rd = rd_cand && !grant_wr;
    aw_word = MEM_ADDR_WIDTH'(s.awaddr >> 2);
    ar_word = MEM_ADDR_WIDTH'(s.araddr >> 2);
    aw_oor = |(s.awaddr >> (MEM_ADDR_WIDTH + 2));
    ar_oor = |(s.araddr >> (MEM_ADDR_WIDTH + 2));
  end
  assign s.awready = grant_wr;
  assign s.wready = grant_wr;
  assign s.arready = grant_rd;
  // RAM data only becomes valid in the first response cycle, so pass it straight through then and hold a copy for stalls
  assign s.rdata = fresh ? ram_dout : rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= GRANT_READ;
      cnt <= '0;
      fresh <= 1'b0;
      rdata_q <= '0;
      s.bvalid <= 1'b0;
      s.bresp <= OKAY;
      s.rvalid <= 1'b0;
      s.rresp <= OKAY;
      ram_wr_en <= 1'b0;
      ram_be <= '0;
      ram_addr <= '0;
      ram_din <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      fresh <= 1'b0;
      if (fresh) rdata_q <= ram_dout;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            last_grant <= GRANT_WRITE;
            s.bvalid <= 1'b1;
            s.bresp <= aw_oor ? SLVERR : OKAY;
            state <= WR_RESP;
            if (!aw_oor) begin
              ram_wr_en <= |s.wstrb;
              ram_be <= s.wstrb;
              ram_addr <= aw_word;
              ram_din <= s.wdata;
            end
          end else if (grant_rd) begin
            last_grant <= GRANT_READ;
            if (ar_oor) begin
              s.rvalid <= 1'b1;
              s.rresp <= SLVERR;
              rdata_q <= '0;
              state <= RD_RESP;
            end else begin
              ram_addr <= ar_word;
              cnt <= CW'(READ_LATENCY - 1);
              state <= RD_WAIT;
            end
          end
        end
        WR_RESP: begin
          if (s.bready) begin
            s.bvalid <= 1'b0;
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            s.rvalid <= 1'b1;
            s.rresp <= OKAY;
            fresh <= 1'b1;
            state <= RD_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (s.rready) begin
            s.rvalid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: directed scoreboard bench for axi_lite_ram_slave with a behavioural one-cycle RAM
module tb_axi_lite_ram_slave;
  import axi_lite_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_lite_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s();
  logic ram_wr_en;
  logic [3:0] ram_be;
  logic [4:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] mem [32];
  logic [31:0] shadow [32];
  int wr_pulses = 0;
  axi_lite_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(5), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .s(s),
    .ram_wr_en(ram_wr_en), .ram_be(ram_be), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );
  always @(posedge clk) begin
    if (ram_wr_en) begin
      wr_pulses++;
      for (int b = 0; b < 4; b++) if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_addr];
  end
  typedef struct {bit rd; logic [1:0] resp; logic [31:0] data;} exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    s.awaddr = a; s.wdata = d; s.wstrb = st; s.awvalid = 1'b1; s.wvalid = 1'b1;
  endtask
  task automatic drive_r(input logic [31:0] a);
    s.araddr = a; s.arvalid = 1'b1;
  endtask
  // waits for a grant, records the expected response, completes the handshake; returns at T+1 plus 1
  task automatic grant(output bit got_w);
    bit ok = 0;
    int w;
    bit oor;
    got_w = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (s.awready && s.wready) begin got_w = 1; ok = 1; end
      else if (s.arready) ok = 1;
      else tick();
    end
    if (!ok) begin timeout("grant"); return; end
    if (got_w) begin
      w = int'((s.awaddr >> 2) & 32'd31);
      oor = (s.awaddr >> 7) != 0;
      if (!oor) for (int b = 0; b < 4; b++) if (s.wstrb[b]) shadow[w][8*b +: 8] = s.wdata[8*b +: 8];
      q.push_back('{rd: 1'b0, resp: oor ? 2'b10 : 2'b00, data: 32'h0});
    end else begin
      w = int'((s.araddr >> 2) & 32'd31);
      oor = (s.araddr >> 7) != 0;
      q.push_back('{rd: 1'b1, resp: oor ? 2'b10 : 2'b00, data: oor ? 32'h0 : shadow[w]});
    end
    @(posedge clk);
    #1;
    if (got_w) begin s.awvalid = 1'b0; s.wvalid = 1'b0; end
    else s.arvalid = 1'b0;
  endtask
  // lat counts cycles from T+1 (=1) to the valid response
  task automatic resp(output int lat, output logic [31:0] d);
    exp_t e;
    bit seen = 0;
    lat = 1;
    d = 'x;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (s.bvalid || s.rvalid) seen = 1;
      else begin tick(); lat++; end
    end
    if (!seen) begin timeout("resp"); return; end
    e = q.pop_front();
    d = s.rdata;
    check("resp_kind", {31'b0, s.rvalid}, {31'b0, e.rd});
    if (e.rd) begin
      check("rresp", {30'b0, s.rresp}, {30'b0, e.resp});
      check("rdata", s.rdata, e.data);
    end else begin
      check("bresp", {30'b0, s.bresp}, {30'b0, e.resp});
    end
    tick();
    check("valid_drop", {31'b0, s.bvalid | s.rvalid}, 32'h0);
  endtask
  initial begin
    bit gw;
    int lat;
    int pulses;
    logic [31:0] d;
    logic [4:0] a0;
    exp_t e;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; shadow[i] = '0; end
    s.awaddr = '0; s.wdata = '0; s.wstrb = '0; s.araddr = '0;
    s.awvalid = 1'b1; s.wvalid = 1'b1; s.arvalid = 1'b1; s.bready = 1'b1; s.rready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_awready", {31'b0, s.awready}, 32'h0);
    check("rst_arready", {31'b0, s.arready}, 32'h0);
    check("rst_bvalid", {31'b0, s.bvalid}, 32'h0);
    check("rst_rvalid", {31'b0, s.rvalid}, 32'h0);
    check("rst_ram_wr_en", {31'b0, ram_wr_en}, 32'h0);
    check("rst_rdata", s.rdata, 32'h0);
    s.awvalid = 1'b0; s.wvalid = 1'b0; s.arvalid = 1'b0;
    rst = 1'b0;
    tick();
    drive_w(32'h8, 32'hDEADBEEF, 4'hF);
    grant(gw);
    check("t1_grant_write", {31'b0, gw}, 32'h1);
    check("t1_ram_wr_en", {31'b0, ram_wr_en}, 32'h1);
    check("t1_ram_addr", {27'b0, ram_addr}, 32'h2);
    check("t1_ram_be", {28'b0, ram_be}, 32'hF);
    check("t1_ram_din", ram_din, 32'hDEADBEEF);
    resp(lat, d);
    check("t1_b_latency", lat, 32'd1);
    check("t1_wr_en_pulse", {31'b0, ram_wr_en}, 32'h0);
    drive_r(32'h8);
    grant(gw);
    check("t2_grant_read", {31'b0, gw}, 32'h0);
    resp(lat, d);
    check("t2_r_latency", lat, 32'd2);
    check("t2_rdata", d, 32'hDEADBEEF);
    drive_w(32'h8, 32'h11223344, 4'b0101);
    grant(gw);
    check("t3_ram_be", {28'b0, ram_be}, 32'h5);
    resp(lat, d);
    drive_r(32'h8);
    grant(gw);
    resp(lat, d);
    check("t3_merged", d, 32'hDE22BE44);
    drive_w(32'h10, 32'hCAFEF00D, 4'hF);
    drive_r(32'h10);
    grant(gw);
    check("t4_first_write", {31'b0, gw}, 32'h1);
    resp(lat, d);
    drive_w(32'h14, 32'h12345678, 4'hF);
    grant(gw);
    check("t4_second_read", {31'b0, gw}, 32'h0);
    resp(lat, d);
    check("t4_read_data", d, 32'hCAFEF00D);
    grant(gw);
    check("t4_pending_write", {31'b0, gw}, 32'h1);
    resp(lat, d);
    pulses = wr_pulses;
    a0 = ram_addr;
    drive_r(32'h80);
    grant(gw);
    check("t5_oor_ram_addr", {27'b0, ram_addr}, {27'b0, a0});
    resp(lat, d);
    check("t5_oor_latency", lat, 32'd1);
    check("t5_oor_rdata", d, 32'h0);
    drive_w(32'h100, 32'hFFFFFFFF, 4'hF);
    grant(gw);
    check("t5_oor_wr_en", {31'b0, ram_wr_en}, 32'h0);
    resp(lat, d);
    check("t5_no_ram_write", wr_pulses, pulses);
    s.rready = 1'b0;
    drive_r(32'h8);
    grant(gw);
    for (int i = 0; i < 10 && !s.rvalid; i++) tick();
    if (!s.rvalid) timeout("t6_rvalid");
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("t6_stall_rvalid", {31'b0, s.rvalid}, 32'h1);
      check("t6_stall_rdata", s.rdata, e.data);
      tick();
    end
    rst = 1'b1;
    tick();
    check("t6_rvalid", {31'b0, s.rvalid}, 32'h0);
    check("t6_rdata", s.rdata, 32'h0);
    check("t6_rresp", {30'b0, s.rresp}, 32'h0);
    check("t6_bvalid", {31'b0, s.bvalid}, 32'h0);
    check("t6_bresp", {30'b0, s.bresp}, 32'h0);
    check("t6_readys", {29'b0, s.awready, s.wready, s.arready}, 32'h0);
    check("t6_ram_wr_en", {31'b0, ram_wr_en}, 32'h0);
    check("t6_ram_be", {28'b0, ram_be}, 32'h0);
    check("t6_ram_addr", {27'b0, ram_addr}, 32'h0);
    check("t6_ram_din", ram_din, 32'h0);
    rst = 1'b0;
    s.rready = 1'b1;
    tick();
    drive_w(32'hC, 32'h0BADF00D, 4'hF);
    drive_r(32'hC);
    grant(gw);
    check("t6_idle_first_write", {31'b0, gw}, 32'h1);
    resp(lat, d);
    grant(gw);
    resp(lat, d);
    check("t6_readback", d, 32'h0BADF00D);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
